// File: rtl/led_pkg.sv
// Shared types and LED decode helpers for the LED bar counter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents: FSM state enum, thermometer decode (count -> bar), one-hot
// decode (peak -> marker, all zero for 0). The decoders return MAX_W bits;
// callers slice the low DATA_W bits, so DATA_W must stay below MAX_W.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int MAX_W = 64;

    // Bit i set iff i < count.
    function automatic logic [MAX_W-1:0] therm_decode(input int unsigned count);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            r[i] = (i < count);
        end
        return r;
    endfunction

    // Single bit at position peak-1; zero when peak is 0.
    function automatic logic [MAX_W-1:0] onehot_decode(input int unsigned peak);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            r[i] = ((i + 1) == peak);
        end
        return r;
    endfunction

endpackage

// File: rtl/led_bar_counter_if.sv
// Handshake and LED bundle between the sample source/consumer and the counter.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carry the valid/ready stalls both ways.
//
// master: the environment (drives in_valid, in_data, out_ready).
// slave:  the counter (drives in_ready, out_valid, out_count, led, peak_led).
interface led_bar_counter_if #(
    parameter int DATA_W = 6
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic [DATA_W-1:0] led;
    logic [DATA_W-1:0] peak_led;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_count, led, peak_led
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_count, led, peak_led
    );

endinterface

// File: rtl/led_peak_hold.sv
// Peak tracker: holds the largest recent count, decaying one step per HOLD_CYC clocks.
// Latency: a qualifying update lands on the same edge it is presented.
// Backpressure: none; it sees every update and always keeps decaying.
//
// Ports: clk, rst (async, active-high), upd_valid/upd_count (new completed
// count), peak (current held value).
module led_peak_hold #(
    parameter int DATA_W   = 6,
    parameter int HOLD_CYC = 1000,
    localparam int CNT_W   = $clog2(DATA_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd_valid,
    input  logic [CNT_W-1:0] upd_count,
    output logic [CNT_W-1:0] peak
);
    // One extra bit so HOLD_CYC=1 still gets a legal, nonzero width.
    localparam int TMR_W = $clog2(HOLD_CYC + 1);

    logic [TMR_W-1:0] timer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak  <= '0;
            timer <= '0;
        end else if (upd_valid && (upd_count >= peak)) begin
            // A new (or equal) peak wins over any decay due this cycle.
            peak  <= upd_count;
            timer <= '0;
        end else if (peak == '0) begin
            timer <= '0;
        end else if (timer == TMR_W'(HOLD_CYC - 1)) begin
            peak  <= peak - 1'b1;
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

endmodule

// File: rtl/led_bar_counter.sv
// Serial popcount of a DATA_W-bit word driving a thermometer LED bar and peak marker.
// Latency: DATA_W+1 clocks from the accepting cycle to the first out_valid cycle.
// Backpressure: holds out_valid in DONE until out_ready; no new word taken until then.
//
// Ports: clk, rst (async, active-high), bus (slave side of led_bar_counter_if):
// in_valid/in_ready/in_data, out_valid/out_ready/out_count, led, peak_led.
module led_bar_counter
    import led_pkg::*;
#(
    parameter int DATA_W   = 6,
    parameter int HOLD_CYC = 1000
) (
    input  logic               clk,
    input  logic               rst,
    led_bar_counter_if.slave   bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt_final;
    logic [CNT_W-1:0]  out_count_q;
    logic [DATA_W-1:0] led_q;
    logic [CNT_W-1:0]  peak;
    logic              accept;
    logic              last_shift;
    logic [MAX_W-1:0]  therm_full;
    logic [MAX_W-1:0]  onehot_full;
    logic              unused_decode_bits;

    assign accept     = (state == IDLE) && bus.in_valid;
    assign last_shift = (state == SHIFT) && (idx == CNT_W'(DATA_W - 1));
    // Count including the bit consumed on the final shift edge, so the
    // result registers on the same edge the FSM enters DONE.
    assign cnt_final  = cnt + CNT_W'(shreg[0]);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = SHIFT;
            SHIFT:   if (last_shift)    state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // ---------------- shift / count datapath ----------------
    // Always runs the full DATA_W shifts so latency never depends on data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
            idx   <= '0;
        end else if (accept) begin
            shreg <= bus.in_data;
            cnt   <= '0;
            idx   <= '0;
        end else if (state == SHIFT) begin
            shreg <= shreg >> 1;
            cnt   <= cnt_final;
            idx   <= idx + 1'b1;
        end
    end

    // ---------------- result and bar registers ----------------
    assign therm_full = therm_decode(32'(cnt_final));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_count_q <= '0;
            led_q       <= '0;
        end else if (last_shift) begin
            out_count_q <= cnt_final;
            led_q       <= therm_full[DATA_W-1:0];
        end
    end

    led_peak_hold #(
        .DATA_W   (DATA_W),
        .HOLD_CYC (HOLD_CYC)
    ) u_peak (
        .clk       (clk),
        .rst       (rst),
        .upd_valid (last_shift),
        .upd_count (cnt_final),
        .peak      (peak)
    );

    // Marker decoded from the registered peak only.
    assign onehot_full = onehot_decode(32'(peak));

    // Decoders are MAX_W wide; only the low DATA_W bits drive pins.
    assign unused_decode_bits = ^{therm_full[MAX_W-1:DATA_W], onehot_full[MAX_W-1:DATA_W]};

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_count = out_count_q;
    assign bus.led       = led_q;
    assign bus.peak_led  = onehot_full[DATA_W-1:0];

endmodule

// File: tb/tb_led_bar_counter.sv
// Bench for led_bar_counter: directed steps then randomized words against a reference model.
// Latency: checks out_valid appears exactly DATA_W+1 clocks after the accepting cycle.
// Backpressure: holds out_ready low for a chosen number of DONE cycles per word.
module tb_led_bar_counter;
    localparam int DW   = 6;
    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led_bar_counter_if #(.DATA_W(DW)) bus();

    led_bar_counter #(
        .DATA_W   (DW),
        .HOLD_CYC (HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    // Peak model: value most recently latched and the edge it was latched on.
    int pk_val = 0;
    int pk_set = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Peak after edge 'at': the latched value loses one step per full HOLD clocks.
    function automatic int mpeak(input int at);
        int d;
        if (pk_val == 0) return 0;
        d = (at - pk_set) / HOLD;
        return (pk_val > d) ? pk_val - d : 0;
    endfunction

    function automatic logic [63:0] bar(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    function automatic logic [63:0] marker(input int p);
        return (p == 0) ? 64'd0 : (64'd1 << (p - 1));
    endfunction

    task automatic check_peak(input string tag);
        chk(tag, 64'(bus.peak_led), marker(mpeak(cyc)));
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_out_count"}, 64'(bus.out_count), 64'd0);
        chk({tag, "_led"},       64'(bus.led),       64'd0);
        chk({tag, "_peak_led"},  64'(bus.peak_led),  64'd0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
            check_peak("idle_peak_led");
        end
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int stall);
        int c;
        int pk_before;
        c = $countones(w);
        chk("accept_in_ready", 64'(bus.in_ready), 64'd1);
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = 6'($urandom);
        for (int k = 1; k < DW; k++) begin
            tick();
            chk("early_out_valid", 64'(bus.out_valid), 64'd0);
            chk("busy_in_ready",   64'(bus.in_ready),  64'd0);
        end
        pk_before = mpeak(cyc);
        tick();
        if (c >= pk_before) begin
            pk_val = c;
            pk_set = cyc;
        end
        chk("done_out_valid", 64'(bus.out_valid), 64'd1);
        chk("done_out_count", 64'(bus.out_count), 64'(c));
        chk("done_led",       64'(bus.led),       bar(c));
        check_peak("done_peak_led");
        // Offer a competing word while stalled; it must not be taken.
        if (stall > 0) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 6'($urandom);
        end
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_out_count", 64'(bus.out_count), 64'(c));
            chk("stall_in_ready",  64'(bus.in_ready),  64'd0);
            check_peak("stall_peak_led");
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("release_out_valid", 64'(bus.out_valid), 64'd0);
        chk("release_in_ready",  64'(bus.in_ready),  64'd1);
        chk("hold_out_count",    64'(bus.out_count), 64'(c));
        chk("hold_led",          64'(bus.led),       bar(c));
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #2;
        reset_values("rst");
        // A request during reset must be ignored.
        bus.in_valid = 1'b1;
        bus.in_data  = 6'b111111;
        tick();
        tick();
        reset_values("rst_hold");
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        pk_val       = 0;
        repeat (5) tick();
        reset_values("post_rst_idle");

        // Directed words.
        send_word(6'b101101, 0);
        chk("dir_led_101101",  64'(bus.led),      64'h0f);
        chk("dir_peak_101101", 64'(bus.peak_led), marker(mpeak(cyc)));
        send_word(6'b111111, 0);
        chk("dir_led_all_ones", 64'(bus.led), 64'h3f);
        send_word(6'b000000, 0);
        chk("dir_led_zero",   64'(bus.led),       64'h00);
        chk("dir_count_zero", 64'(bus.out_count), 64'd0);

        // Back-pressure.
        send_word(6'b110011, 10);
        send_word(6'b010000, 0);

        // Decay to zero, then a fresh peak of 4 and a count-3 word mid-decay.
        idle(40);
        chk("decayed_out", 64'(bus.peak_led), 64'd0);
        send_word(6'b111100, 0);
        chk("peak4_marker", 64'(bus.peak_led), 64'h08);
        idle(2);
        send_word(6'b000111, 0);
        chk("peak3_reload", 64'(bus.peak_led), 64'h04);
        idle(20);

        // Reset during the third SHIFT cycle.
        bus.in_data  = 6'b110110;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        reset_values("abort");
        tick();
        rst    = 1'b0;
        pk_val = 0;
        idle(10);
        send_word(6'b011011, 0);

        // Randomized words with random stalls and idle gaps.
        for (int n = 0; n < 40; n++) begin
            send_word(6'($urandom), int'($urandom_range(0, 3)));
            idle(int'($urandom_range(0, 10)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
